// File: rtl/sc_fifo.sv
// sc_fifo: single-clock show-ahead (first-word-fall-through) FIFO.
//
// The head entry is presented on q combinationally whenever the FIFO is
// non-empty. Writes into a full FIFO and reads from an empty FIFO are
// dropped internally, so the pointers and the count can never be corrupted.
//
// Ports:
//   CLK           clock; all state changes on the rising edge
//   RST_N         asynchronous active-low reset
//   sclr          synchronous clear, active high, overrides wrreq/rdreq
//   data          write data
//   wrreq         write request
//   full          FIFO holds DEPTH entries
//   rdreq         read acknowledge; pops the current head
//   q             current head entry (valid while empty==0)
//   empty         FIFO holds 0 entries
//   usedw         entry count modulo DEPTH (reads 0 when full)
//   almost_full   count >= ALMOST_FULL_VALUE
//   almost_empty  count <  ALMOST_EMPTY_VALUE
//   eccstatus     always 2'b00, no ECC
//
// Handshake: a write is accepted at a rising edge when wrreq=1 and full=0;
// a read is accepted when rdreq=1 and empty=0. rdreq acts as an acknowledge
// of the word already shown on q. An unaccepted request has no effect.
module sc_fifo #(
  parameter int DATA_WIDTH         = 32,
  parameter int DEPTH              = 4,
  parameter int WIDTHU             = $clog2(DEPTH),
  parameter int ALMOST_FULL_VALUE  = DEPTH - 1,
  parameter int ALMOST_EMPTY_VALUE = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  sclr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wrreq,
  output logic                  full,
  input  logic                  rdreq,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  empty,
  output logic [WIDTHU-1:0]     usedw,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [1:0]            eccstatus
);

  // Thresholds sized to the count register so comparisons are width-exact.
  localparam logic [WIDTHU:0] DEPTH_CNT = (WIDTHU + 1)'(DEPTH);
  localparam logic [WIDTHU:0] AF_CNT    = (WIDTHU + 1)'(ALMOST_FULL_VALUE);
  localparam logic [WIDTHU:0] AE_CNT    = (WIDTHU + 1)'(ALMOST_EMPTY_VALUE);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [WIDTHU-1:0]     wr_ptr;
  logic [WIDTHU-1:0]     rd_ptr;
  logic [WIDTHU:0]       count;

  logic do_wr;
  logic do_rd;

  // Accepted operations are qualified by the registered flags, so a write
  // while full is dropped even when a read frees a slot in the same cycle.
  assign do_wr = wrreq && !full && !sclr;
  assign do_rd = rdreq && !empty && !sclr;

  // Pointers and count; sclr behaves like reset but at the clock edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + WIDTHU'(1);
      if (do_rd) rd_ptr <= rd_ptr + WIDTHU'(1);
      if (do_wr && !do_rd)      count <= count + (WIDTHU + 1)'(1);
      else if (do_rd && !do_wr) count <= count - (WIDTHU + 1)'(1);
    end
  end

  // Storage is deliberately not reset; contents are unreachable until written.
  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr] <= data;
  end

  // Show-ahead: head entry visible without a read strobe.
  assign q = mem[rd_ptr];

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_CNT);
  assign usedw        = count[WIDTHU-1:0];
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count < AE_CNT);
  assign eccstatus    = 2'b00;

endmodule

// File: tb/tb_sc_fifo.sv
// Testbench for sc_fifo: directed sequences with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_sc_fifo;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int WU    = 2;
  localparam int AFV   = DEPTH - 1;
  localparam int AEV   = 1;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic          sclr = 1'b0;
  logic [W-1:0]  data = '0;
  logic          wrreq = 1'b0;
  logic          rdreq = 1'b0;
  logic          full;
  logic [W-1:0]  q;
  logic          empty;
  logic [WU-1:0] usedw;
  logic          almost_full;
  logic          almost_empty;
  logic [1:0]    eccstatus;

  sc_fifo #(
    .DATA_WIDTH(W),
    .DEPTH(DEPTH)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .sclr(sclr),
    .data(data),
    .wrreq(wrreq),
    .full(full),
    .rdreq(rdreq),
    .q(q),
    .empty(empty),
    .usedw(usedw),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .eccstatus(eccstatus)
  );

  int total = 0;
  int bad   = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The FIFO is just an ordered queue of at most DEPTH words.
  logic [W-1:0] exp_q[$];
  bit m_wr, m_rd;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      exp_q.delete();
    end else if (sclr) begin
      exp_q.delete();
    end else begin
      m_wr = wrreq && (exp_q.size() < DEPTH);
      m_rd = rdreq && (exp_q.size() > 0);
      if (m_rd) void'(exp_q.pop_front());
      if (m_wr) exp_q.push_back(data);
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge CLK) begin
    if (run_chk && RST_N) begin
      chk("sb_empty", W'(empty), W'(exp_q.size() == 0));
      chk("sb_full", W'(full), W'(exp_q.size() == DEPTH));
      chk("sb_usedw", W'(usedw), W'(exp_q.size() % DEPTH));
      chk("sb_almost_full", W'(almost_full), W'(exp_q.size() >= AFV));
      chk("sb_almost_empty", W'(almost_empty), W'(exp_q.size() < AEV));
      chk("sb_ecc", W'(eccstatus), '0);
      if (exp_q.size() > 0) chk("sb_q", q, exp_q[0]);
    end
  end

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge; returns 1 unit after
  // the next rising edge so outputs can be checked right away.
  task automatic cyc(input bit w, input bit r, input logic [W-1:0] d, input bit c = 1'b0);
    wrreq = w;
    rdreq = r;
    data  = d;
    sclr  = c;
    @(posedge CLK);
    #1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    sclr  = 1'b0;
  endtask

  int unsigned val;

  initial begin
    // Reset state
    #1;
    chk("rst_empty", W'(empty), 1);
    chk("rst_full", W'(full), 0);
    chk("rst_usedw", W'(usedw), 0);
    chk("rst_almost_empty", W'(almost_empty), 1);
    chk("rst_almost_full", W'(almost_full), 0);
    chk("rst_ecc", W'(eccstatus), 0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    run_chk = 1'b1;

    // Fill with A1..D4
    cyc(1, 0, 32'hA1);
    chk("wr1_empty", W'(empty), 0);
    chk("wr1_q", q, 32'hA1);
    chk("wr1_usedw", W'(usedw), 1);
    chk("wr1_almost_empty", W'(almost_empty), 0);
    cyc(1, 0, 32'hB2);
    chk("wr2_usedw", W'(usedw), 2);
    chk("wr2_almost_full", W'(almost_full), 0);
    cyc(1, 0, 32'hC3);
    chk("wr3_usedw", W'(usedw), 3);
    chk("wr3_almost_full", W'(almost_full), 1);
    cyc(1, 0, 32'hD4);
    chk("wr4_full", W'(full), 1);
    chk("wr4_usedw", W'(usedw), 0);
    // Overflow write is dropped
    cyc(1, 0, 32'hFF);
    chk("ovf_full", W'(full), 1);
    chk("ovf_q", q, 32'hA1);
    // Drain order
    cyc(0, 1, '0);
    chk("drain1_q", q, 32'hB2);
    chk("drain1_usedw", W'(usedw), 3);
    cyc(0, 1, '0);
    chk("drain2_q", q, 32'hC3);
    cyc(0, 1, '0);
    chk("drain3_q", q, 32'hD4);
    cyc(0, 1, '0);
    chk("drain4_empty", W'(empty), 1);

    // Simultaneous read/write at count 2
    cyc(1, 0, 32'h11);
    cyc(1, 0, 32'h22);
    cyc(1, 1, 32'h33);
    chk("rw2_usedw", W'(usedw), 2);
    chk("rw2_q", q, 32'h22);
    cyc(1, 0, 32'h44);
    cyc(1, 0, 32'h55);
    chk("rw_pre_full", W'(full), 1);
    // At full: read accepted, write dropped
    cyc(1, 1, 32'h66);
    chk("rwfull_full", W'(full), 0);
    chk("rwfull_usedw", W'(usedw), 3);
    chk("rwfull_q", q, 32'h33);
    cyc(0, 1, '0);
    chk("rwfull_d1", q, 32'h44);
    cyc(0, 1, '0);
    chk("rwfull_d2", q, 32'h55);
    cyc(0, 1, '0);
    chk("rwfull_empty", W'(empty), 1);

    // Underflow
    cyc(0, 1, '0);
    chk("udf_empty", W'(empty), 1);
    chk("udf_usedw", W'(usedw), 0);
    cyc(1, 1, 32'h55);
    chk("udfw_empty", W'(empty), 0);
    chk("udfw_q", q, 32'h55);
    chk("udfw_usedw", W'(usedw), 1);
    cyc(0, 1, '0);
    chk("udfw_drained", W'(empty), 1);

    // 10 fill/drain rounds across pointer wrap
    val = 32'h100;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, W'(val + r * DEPTH + i));
      chk("wrap_full", W'(full), 1);
      for (int i = 0; i < DEPTH; i++) begin
        chk("wrap_q", q, W'(val + r * DEPTH + i));
        cyc(0, 1, '0);
      end
      chk("wrap_empty", W'(empty), 1);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
          ($urandom_range(0, 31) == 0));
    end

    // Async reset mid-cycle with 3 entries
    cyc(0, 0, '0, 1'b1);
    cyc(1, 0, 32'hE1);
    cyc(1, 0, 32'hE2);
    cyc(1, 0, 32'hE3);
    chk("pre_rst_usedw", W'(usedw), 3);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_empty", W'(empty), 1);
    chk("arst_usedw", W'(usedw), 0);
    chk("arst_full", W'(full), 0);
    // Requests during reset are ignored
    wrreq = 1'b1;
    data  = 32'h77;
    @(posedge CLK);
    #1;
    wrreq = 1'b0;
    RST_N = 1'b1;
    #1;
    chk("arst_ignored_wr", W'(empty), 1);

    // sclr with 3 entries, overriding wr/rd
    cyc(1, 0, 32'hF1);
    cyc(1, 0, 32'hF2);
    cyc(1, 0, 32'hF3);
    chk("pre_sclr_usedw", W'(usedw), 3);
    cyc(1, 1, 32'h99, 1'b1);
    chk("sclr_empty", W'(empty), 1);
    chk("sclr_usedw", W'(usedw), 0);
    chk("sclr_almost_empty", W'(almost_empty), 1);
    cyc(1, 0, 32'hAB);
    chk("post_sclr_q", q, 32'hAB);

    @(negedge CLK);
    run_chk = 1'b0;
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
